// File: rtl/reduceron_io_hub.sv
// IO hub for the Reduceron core bus: per-channel output FIFOs merged round-robin onto
// one tagged TX stream, a one-entry RX register, a run-cycle counter with watchdog, and result capture.
module reduceron_io_hub #(
  parameter int AW      = 15,
  parameter int DW      = 15,
  parameter int RW      = 18,
  parameter int NCH     = 4,
  parameter int DEPTH   = 8,
  parameter int CW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] ioaddr,
  input  logic          iowrite,
  input  logic          ioread,
  input  logic [DW-1:0] iowd,
  output logic [DW-1:0] iord,
  output logic          iostall,
  input  logic          finish_in,
  input  logic [RW-1:0] result_in,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [11:0]   tx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          done,
  output logic          timeout,
  output logic [RW-1:0] result_out,
  output logic [CW-1:0] cycles
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [AW-1:0] A_RX   = AW'(16);
  localparam logic [AW-1:0] A_CYC  = AW'(32);
  localparam logic [AW-1:0] A_STAT = AW'(33);

  logic [7:0]      mem    [NCH][DEPTH];
  logic [PW-1:0]   rd_ptr [NCH];
  logic [PW-1:0]   wr_ptr [NCH];
  logic [CNTW-1:0] cnt    [NCH];

  logic [NCH-1:0] hit, full, nonempty, push, pop, avail;
  logic [CHW-1:0] ptr, cur_ch, gnt, idx;
  logic           gnt_found;
  logic [7:0]     gnt_byte;
  logic           rx_full, rx_rd;
  logic [7:0]     rx_byte;
  logic           unused_iowd;

  assign unused_iowd = ^iowd[DW-1:8];

  // Full is judged on the registered count, so a pop in the same cycle does not release the stall.
  always_comb begin
    hit = '0; full = '0; nonempty = '0; push = '0; pop = '0; avail = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c]      = (ioaddr == AW'(c));
      full[c]     = (cnt[c] == CNTW'(DEPTH));
      nonempty[c] = (cnt[c] != '0);
      push[c]     = iowrite && hit[c] && !full[c];
      pop[c]      = tx_valid && tx_ready && (cur_ch == CHW'(c));
      avail[c]    = (cnt[c] > (pop[c] ? CNTW'(1) : CNTW'(0)));
    end
  end

  assign iostall  = iowrite && |(hit & full);
  assign rx_ready = !rx_full;
  assign rx_rd    = ioread && !iowrite && (ioaddr == A_RX);

  // The byte being popped is still at the head, so a re-grant of that channel takes the next entry.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CHW'((int'(ptr) + i) % NCH);
      if (!gnt_found && avail[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
    gnt_byte = pop[gnt] ? mem[gnt][rd_ptr[gnt] + PW'(1)] : mem[gnt][rd_ptr[gnt]];
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NCH; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= iowd[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        cnt[c] <= cnt[c] + CNTW'(push[c]) - CNTW'(pop[c]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      cur_ch   <= '0;
      ptr      <= '0;
    end else if (!tx_valid || tx_ready) begin
      tx_valid <= gnt_found;
      if (gnt_found) begin
        tx_data <= {4'(gnt), gnt_byte};
        cur_ch  <= gnt;
        ptr     <= CHW'((int'(gnt) + 1) % NCH);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_byte <= '0;
    end else if (rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_byte <= rx_data;
    end else if (rx_rd) begin
      rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iord <= '0;
    end else begin
      iord <= '0;
      if (ioread && !iowrite) begin
        case (ioaddr)
          A_RX:    if (rx_full) iord <= DW'({1'b1, rx_byte});
          A_CYC:   iord <= DW'(cycles);
          A_STAT:  iord <= DW'({timeout, done, rx_full, |nonempty});
          default: iord <= '0;
        endcase
      end
    end
  end

  // The counter still steps on the edge that sets done, then freezes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result_out <= '0;
    end else if (!done) begin
      if (cycles != '1) cycles <= cycles + CW'(1);
      if (finish_in) begin
        result_out <= result_in;
        done       <= 1'b1;
      end
      if (TIMEOUT != 0 && cycles == CW'(TIMEOUT - 1)) begin
        timeout <= 1'b1;
        done    <= 1'b1;
      end
    end
  end

endmodule
